// File: rtl/excitation_source.sv
// Excitation source: one impulse per pitch period (voiced) or LFSR-signed noise (unvoiced).
// Outputs are registered one clock after sample_stb; period_done marks each period boundary.
module excitation_source #(
  parameter logic [16:0] LFSR_SEED    = 17'h00001,
  parameter logic [7:0]  NOISE_PERIOD = 8'd64
) (
  input  logic        clk,
  input  logic        rst_an,
  input  logic        sample_stb,
  input  logic [7:0]  period_in,
  input  logic [15:0] amp_in,
  output logic [15:0] source_out,
  output logic        source_stb,
  output logic        period_done
);

  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] amp_lat_q, amp_lat_d;
  logic        voiced_lat_q, voiced_lat_d;
  logic [16:0] lfsr_q, lfsr_d;
  logic [15:0] source_q, source_d;
  logic        source_stb_q, source_stb_d;
  logic        period_done_q, period_done_d;

  logic        boundary;
  logic [15:0] mag_in, mag_lat;
  logic [15:0] noise_in, noise_lat;

  assign boundary = (cnt_q == 8'd0);

  // Halving the amplitude keeps the magnitude within 0..32767, so negation never yields 0x8000.
  assign mag_in    = {1'b0, amp_in[15:1]};
  assign mag_lat   = {1'b0, amp_lat_q[15:1]};
  assign noise_in  = lfsr_q[0] ? (~mag_in + 16'd1)  : mag_in;
  assign noise_lat = lfsr_q[0] ? (~mag_lat + 16'd1) : mag_lat;

  always_comb begin
    cnt_d         = cnt_q;
    amp_lat_d     = amp_lat_q;
    voiced_lat_d  = voiced_lat_q;
    lfsr_d        = lfsr_q;
    source_d      = source_q;
    source_stb_d  = 1'b0;
    period_done_d = 1'b0;

    if (sample_stb) begin
      source_stb_d = 1'b1;
      lfsr_d       = {lfsr_q[15:0], lfsr_q[16] ^ lfsr_q[13]};
      if (boundary) begin
        amp_lat_d     = amp_in;
        voiced_lat_d  = (period_in != 8'd0);
        period_done_d = 1'b1;
        if (period_in != 8'd0) begin
          source_d = mag_in;
          cnt_d    = period_in - 8'd1;
        end else begin
          source_d = noise_in;
          cnt_d    = NOISE_PERIOD - 8'd1;
        end
      end else begin
        cnt_d    = cnt_q - 8'd1;
        source_d = voiced_lat_q ? 16'd0 : noise_lat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_an) begin
      cnt_q         <= 8'd0;
      amp_lat_q     <= 16'd0;
      voiced_lat_q  <= 1'b0;
      lfsr_q        <= LFSR_SEED;
      source_q      <= 16'd0;
      source_stb_q  <= 1'b0;
      period_done_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      amp_lat_q     <= amp_lat_d;
      voiced_lat_q  <= voiced_lat_d;
      lfsr_q        <= lfsr_d;
      source_q      <= source_d;
      source_stb_q  <= source_stb_d;
      period_done_q <= period_done_d;
    end
  end

  assign source_out  = source_q;
  assign source_stb  = source_stb_q;
  assign period_done = period_done_q;

endmodule
